// File: rtl/inst_mem_responder.sv
// inst_mem_responder: responder end of the instruction-fetch handshake.
// A DEPTH-word instruction store with a program-load port. Each fetch is
// answered LATENCY cycles after acceptance with a one-cycle ready pulse.
// Optional feature macro: INST_MEM_ALIGN_CHECK_EN adds inst_mem_out_error,
// which flags misaligned or out-of-range fetches (data forced to zero).
module inst_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_mem_out_addr,
  input  logic        inst_mem_out_valid,
  output logic [31:0] inst_mem_out_data,
  output logic        inst_mem_out_ready,
`ifdef INST_MEM_ALIGN_CHECK_EN
  output logic        inst_mem_out_error,
`endif
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] rd_addr;
  logic        rd_en;
  logic        rd_in_range;
  logic        rd_bad;
  logic [31:0] rd_data;
  logic        ld_in_range;

  // Byte-address bits [1:0] never select anything in the word store.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{load_addr[1:0], rd_addr[1:0]};

  // Read path: the addressed word, or zero when the fetch is unusable.
  always_comb begin
    rd_in_range = (rd_addr >> (AW + 2)) == 32'd0;
`ifdef INST_MEM_ALIGN_CHECK_EN
    rd_bad = !rd_in_range || (rd_addr[1:0] != 2'b00);
`else
    rd_bad = !rd_in_range;
`endif
    rd_data = rd_bad ? 32'h0 : mem_q[rd_addr[AW+1:2]];
  end

  // Fetch FSM: accept, count down the latency, respond once, wait for release.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;
    case (state_q)
      IDLE: begin
        // A zero-latency countdown reads straight from the incoming address.
        rd_addr = inst_mem_out_addr;
        if (inst_mem_out_valid) begin
          addr_d = inst_mem_out_addr;
          cnt_d  = CNT_INIT;
          if (CNT_INIT == 4'd0) begin
            rd_en   = 1'b1;
            state_d = RESPOND;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!inst_mem_out_valid) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            rd_en   = 1'b1;
            state_d = RESPOND;
          end
        end
      end
      RESPOND: state_d = RELEASE;
      default: if (!inst_mem_out_valid) state_d = IDLE;
    endcase
    data_d = rd_en ? rd_data : data_q;
    err_d  = rd_en ? rd_bad : err_q;
  end

  // Control and response registers; the store itself is not reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      cnt_q   <= 4'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign ld_in_range = (load_addr >> (AW + 2)) == 32'd0;

  // Program-load writes; a same-edge fetch read still sees the old word.
  always_ff @(posedge clk) begin
    if (load_we && ld_in_range) mem_q[load_addr[AW+1:2]] <= load_data;
  end

  assign inst_mem_out_data  = data_q;
  assign inst_mem_out_ready = (state_q == RESPOND);
  assign busy               = (state_q != IDLE);
`ifdef INST_MEM_ALIGN_CHECK_EN
  assign inst_mem_out_error = (state_q == RESPOND) && err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Responder end of the instruction-fetch interface (addr/valid/data/ready) driven by the core's fetch stage.
- Holds a word-addressed instruction store of DEPTH words, with a load port for program image download.
- Serves each fetch request after a programmable latency.
- Sits between the core fetch stage and the board-level program loader.

Parameters:
- DEPTH, 1024, number of 32-bit words in the store (power of two, at least 2).
- LATENCY, 1, cycles from request acceptance to ready (range 1 to 15).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- inst_mem_out_addr  in  32  byte address of the requested instruction.
- inst_mem_out_valid  in  1  request level; held high until ready is seen.
- inst_mem_out_data  out  32  instruction word; valid only in the ready cycle.
- inst_mem_out_ready  out  1  one-cycle pulse: data is valid this cycle.
- load_we  in  1  program-load write enable.
- load_addr  in  32  byte address for the load write.
- load_data  in  32  word written on load_we.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0, asynchronous): state goes to IDLE. inst_mem_out_ready=0, inst_mem_out_data=0, busy=0, counter=0. Store contents are not cleared.
- Word index: addr[log2(DEPTH)+1:2]. addr[1:0] is ignored. If addr >= 4*DEPTH, data returned is 32'h0. The same rules apply to load_addr; out-of-range load writes are dropped.
- States and transitions:
  - IDLE: when valid=1, latch addr and set cnt=LATENCY-1. If cnt==0, perform the store read into the data register and go to RESPOND. Otherwise go to WAIT.
  - WAIT: if valid=0, abort to IDLE; no ready is issued. Otherwise decrement cnt. When cnt reaches 0, perform the store read and go to RESPOND.
  - RESPOND: ready=1 for exactly this cycle, with data held. Next state is RELEASE unconditionally.
  - RELEASE: ready=0. Stay in RELEASE until valid=0, then go to IDLE. This guarantees one response per request, because the requester keeps valid high through the ready cycle.
- Latency: valid first high in cycle N (state IDLE) gives ready high in cycle N+LATENCY.
- Address changes after acceptance are ignored until the next request.
- Load port: a write is performed on every cycle where load_we=1, in any state.
- Load write to the word being read in the same edge: the read returns the old contents (read-before-write). A load write in an earlier WAIT cycle is visible to the read.
- inst_mem_out_data is held from RESPOND until the next store read, or zero after reset.
- Reset asserted mid-operation: immediate return to IDLE; any pending response is lost.

Optional Feature:
- Macro: INST_MEM_ALIGN_CHECK_EN.
- When defined:
  - Adds output port inst_mem_out_error (1 bit, reset 0).
  - In RESPOND, error=1 if the latched addr[1:0]!=0 or the address is out of range.
  - On error, inst_mem_out_data=32'h0.
  - error is 0 in all other states.
- When undefined: no error port; misaligned addresses are silently truncated and out-of-range addresses return 0.

Test Plan:
- Reset then load 0x00000093 at addr 0x10 (LATENCY=1); hold valid with addr=0x10 -> ready pulses 1 cycle after valid rises, data=0x00000093. Ready stays 0 while valid remains high in RELEASE.
- LATENCY=4, request addr 0x0 holding 0xDEADBEEF -> ready exactly 4 cycles after valid rises, busy high 5 cycles. Changing addr to 0x4 in WAIT has no effect on returned data.
- Valid dropped in cycle 2 of WAIT (LATENCY=4) -> no ready pulse, state IDLE. A following request to 0x8 returns the correct word with full latency.
- Same-edge load_we to addr 0x20 (new 0x1111) as the read of 0x20 (old 0x2222) -> response 0x2222. The next request returns 0x1111.
- Request addr 4*DEPTH -> data 0x0. With INST_MEM_ALIGN_CHECK_EN, error=1 in the ready cycle; request to 0x22 also gives error=1, data 0.
- reset driven low asynchronously mid-WAIT -> ready and busy go to 0 without waiting for a clock edge. After release, a new request completes normally.
